ncl_dr_counter_clk: RTL and testbench

- Clocked, parametrised successor to the team's 32-bit dual-rail NCL ripple counter.
- Presents a WIDTH-bit count to NCL logic as alternating dual-rail NULL/DATA wavefronts, paced by the consumer's completion signal.
- Adds up/down counting, programmable step, synchronous load, and wrap or saturate modes.
- Sits at the boundary between the clocked control domain and clockless NCL pipelines, replacing the self-looping auto-produce/auto-consume counter ring.

---
 rtl/ncl_dr_counter_clk.sv | 153 +++++++++++++++
 tb/tb_ncl_dr_counter_clk.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/ncl_dr_counter_clk.sv
// Clocked dual-rail NCL counter: presents a WIDTH-bit count as NULL/DATA wavefronts
// paced by a synchronised consumer completion (ki), with up/down, load and wrap/saturate.
module ncl_dr_counter_clk #(
  parameter int unsigned      WIDTH       = 32,
  parameter logic [WIDTH-1:0] STEP        = WIDTH'(1),
  parameter bit               SATURATE    = 1'b0,
  parameter logic [WIDTH-1:0] RESET_VAL   = '0,
  parameter int unsigned      SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             init_n,
  input  logic             en,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             ki,
  output logic [WIDTH-1:0] sum_t,
  output logic [WIDTH-1:0] sum_f,
  output logic             cout_t,
  output logic             cout_f,
  output logic             ko,
  output logic [WIDTH-1:0] count
);

  typedef enum logic [0:0] {StNull, StData} state_e;

  state_e state_q, state_d;

  logic [SYNC_STAGES-1:0] ki_sync_q;
  logic                   kis;
  logic                   advance;

  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;

  logic [WIDTH:0]   up_sum;
  logic [WIDTH:0]   dn_diff;
  logic             ovf, unf;

  logic [WIDTH-1:0] sum_t_q, sum_t_d;
  logic [WIDTH-1:0] sum_f_q, sum_f_d;
  logic             cout_t_q, cout_t_d;
  logic             cout_f_q, cout_f_d;
  logic             ko_q, ko_d;

  // Raw ki is asynchronous to clk; only the last flop of this chain feeds logic.
  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      ki_sync_q <= '0;
    end else begin
      ki_sync_q <= {ki_sync_q[SYNC_STAGES-2:0], ki};
    end
  end

  assign kis = ki_sync_q[SYNC_STAGES-1];

  always_comb begin
    state_d = state_q;
    advance = 1'b0;
    unique case (state_q)
      StNull: begin
        if (kis) state_d = StData;
      end
      StData: begin
        if (!kis) begin
          state_d = StNull;
          advance = 1'b1;
        end
      end
      default: state_d = StNull;
    endcase
  end

  // One extra bit catches carry out (up) and borrow (down).
  assign up_sum  = {1'b0, count_q} + {1'b0, STEP};
  assign dn_diff = {1'b0, count_q} - {1'b0, STEP};
  assign ovf     = up_sum[WIDTH];
  assign unf     = dn_diff[WIDTH];

  always_comb begin
    count_d = count_q;
    wrap_d  = wrap_q;
    if (advance) begin
      if (load) begin
        count_d = load_val;
        wrap_d  = 1'b0;
      end else if (en) begin
        if (dir) begin
          wrap_d  = ovf;
          count_d = (ovf && SATURATE) ? '1 : up_sum[WIDTH-1:0];
        end else begin
          wrap_d  = unf;
          count_d = (unf && SATURATE) ? '0 : dn_diff[WIDTH-1:0];
        end
      end
    end
  end

  // count_q only moves when leaving DATA, so it is the value to present on entry.
  always_comb begin
    sum_t_d  = '0;
    sum_f_d  = '0;
    cout_t_d = 1'b0;
    cout_f_d = 1'b0;
    ko_d     = 1'b0;
    if (state_d == StData) begin
      sum_t_d  = count_q;
      sum_f_d  = ~count_q;
      cout_t_d = wrap_q;
      cout_f_d = ~wrap_q;
      ko_d     = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      state_q  <= StNull;
      count_q  <= RESET_VAL;
      wrap_q   <= 1'b0;
      sum_t_q  <= '0;
      sum_f_q  <= '0;
      cout_t_q <= 1'b0;
      cout_f_q <= 1'b0;
      ko_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      wrap_q   <= wrap_d;
      sum_t_q  <= sum_t_d;
      sum_f_q  <= sum_f_d;
      cout_t_q <= cout_t_d;
      cout_f_q <= cout_f_d;
      ko_q     <= ko_d;
    end
  end

  assign sum_t  = sum_t_q;
  assign sum_f  = sum_f_q;
  assign cout_t = cout_t_q;
  assign cout_f = cout_f_q;
  assign ko     = ko_q;
  assign count  = count_q;

  a_rails_exclusive: assert property (@(posedge clk) disable iff (!init_n)
    ((sum_t & sum_f) == '0) && !(cout_t && cout_f));

  a_data_stable: assert property (@(posedge clk) disable iff (!init_n)
    (ko && $past(ko)) |-> ($stable(sum_t) && $stable(sum_f) && $stable(cout_t)));

  a_null_empty: assert property (@(posedge clk) disable iff (!init_n)
    !ko |-> (sum_t == '0 && sum_f == '0 && !cout_t && !cout_f));

endmodule

// File: tb/tb_ncl_dr_counter_clk.sv
// Scoreboard bench: three counter configurations; expected DATA wavefronts are queued by the
// stimulus and checked by a negedge monitor whenever ko rises.
module tb_ncl_dr_counter_clk;

  typedef struct packed {
    logic [31:0] val;
    logic        wrap;
  } exp_t;

  logic        clk;
  logic        init_n;
  logic        en, dir, load;
  logic [31:0] load_val;
  logic [2:0]  ki;

  logic [31:0] w_st, w_sf, w_cnt;
  logic [3:0]  r_st, r_sf, r_cnt;
  logic [3:0]  s_st, s_sf, s_cnt;

  logic [31:0] st [3];
  logic [31:0] sf [3];
  logic [31:0] cnt [3];
  logic [2:0]  ct, cf, ko;

  int checks = 0;
  int errors = 0;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  // Instance 0: defaults (32-bit, STEP 1, wrap). 1: 4-bit STEP 3 wrap. 2: 4-bit STEP 2 saturate.
  ncl_dr_counter_clk u_wide (
    .clk(clk), .init_n(init_n), .en(en), .dir(dir), .load(load), .load_val(load_val),
    .ki(ki[0]), .sum_t(w_st), .sum_f(w_sf), .cout_t(ct[0]), .cout_f(cf[0]), .ko(ko[0]),
    .count(w_cnt)
  );

  ncl_dr_counter_clk #(.WIDTH(4), .STEP(4'd3), .SATURATE(1'b0), .RESET_VAL(4'd0)) u_wrap (
    .clk(clk), .init_n(init_n), .en(en), .dir(dir), .load(load), .load_val(load_val[3:0]),
    .ki(ki[1]), .sum_t(r_st), .sum_f(r_sf), .cout_t(ct[1]), .cout_f(cf[1]), .ko(ko[1]),
    .count(r_cnt)
  );

  ncl_dr_counter_clk #(.WIDTH(4), .STEP(4'd2), .SATURATE(1'b1), .RESET_VAL(4'd9)) u_sat (
    .clk(clk), .init_n(init_n), .en(en), .dir(dir), .load(load), .load_val(load_val[3:0]),
    .ki(ki[2]), .sum_t(s_st), .sum_f(s_sf), .cout_t(ct[2]), .cout_f(cf[2]), .ko(ko[2]),
    .count(s_cnt)
  );

  assign st[0]  = w_st;
  assign sf[0]  = w_sf;
  assign cnt[0] = w_cnt;
  assign st[1]  = {28'd0, r_st};
  assign sf[1]  = {28'd0, r_sf};
  assign cnt[1] = {28'd0, r_cnt};
  assign st[2]  = {28'd0, s_st};
  assign sf[2]  = {28'd0, s_sf};
  assign cnt[2] = {28'd0, s_cnt};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mask_of(input int i);
    return (i == 0) ? 32'hFFFF_FFFF : 32'h0000_000F;
  endfunction

  task automatic check(input string name, input int i, input logic [31:0] act,
                       input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s dut%0d: got %h, required %h (t=%0t)", name, i, act, req, $time);
    end
  endtask

  task automatic push(input int i, input logic [31:0] val, input logic wrap);
    exp_t e;
    e.val  = val;
    e.wrap = wrap;
    case (i)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic wait_ko(input int i, input logic val);
    for (int n = 0; n < 20; n++) begin
      @(posedge clk);
      #1;
      if (ko[i] == val) return;
    end
    checks++;
    errors++;
    $display("FAIL ko_timeout dut%0d: ko stuck at %b, required %b (t=%0t)", i, ko[i], val,
             $time);
  endtask

  // Full four-phase cycle: drop ki (advance if in DATA), wait NULL, raise ki, wait DATA.
  task automatic wave(input int i);
    ki[i] = 1'b0;
    wait_ko(i, 1'b0);
    ki[i] = 1'b1;
    wait_ko(i, 1'b1);
  endtask

  // Monitor: invariants every cycle, scoreboard pop on each new DATA wavefront.
  logic [2:0]  ko_prev = '0;
  logic [31:0] st_prev [3];
  logic [31:0] sf_prev [3];

  always @(negedge clk) begin
    exp_t e;
    bit   got;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (((st[i] & sf[i]) != 0) || (ct[i] && cf[i])) begin
        errors++;
        $display("FAIL rail_exclusive dut%0d: t=%h f=%h ct=%b cf=%b, required no double-high",
                 i, st[i], sf[i], ct[i], cf[i]);
      end
      if (!ko[i]) begin
        check("null_rails", i, st[i] | sf[i] | {31'd0, ct[i] | cf[i]}, 32'd0);
      end else if (ko_prev[i]) begin
        check("data_stable_t", i, st[i], st_prev[i]);
        check("data_stable_f", i, sf[i], sf_prev[i]);
      end else begin
        got = 1'b0;
        case (i)
          0: if (q0.size() > 0) begin e = q0.pop_front(); got = 1'b1; end
          1: if (q1.size() > 0) begin e = q1.pop_front(); got = 1'b1; end
          default: if (q2.size() > 0) begin e = q2.pop_front(); got = 1'b1; end
        endcase
        if (!got) begin
          checks++;
          errors++;
          $display("FAIL unexpected_data dut%0d: got DATA %h, required no wavefront", i, st[i]);
        end else begin
          check("sum_t", i, st[i], e.val);
          check("sum_f", i, sf[i], ~e.val & mask_of(i));
          check("cout_t", i, {31'd0, ct[i]}, {31'd0, e.wrap});
          check("cout_f", i, {31'd0, cf[i]}, {31'd0, ~e.wrap});
          check("count", i, cnt[i], e.val);
        end
      end
      ko_prev[i] = ko[i];
      st_prev[i] = st[i];
      sf_prev[i] = sf[i];
    end
  end

  initial begin
    init_n   = 1'b1;
    en       = 1'b1;
    dir      = 1'b1;
    load     = 1'b0;
    load_val = '0;
    ki       = 3'b001;
    #1 init_n = 1'b0;

    // Reset and first wavefront on the wide counter.
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) check("reset_ko", i, {31'd0, ko[i]}, 32'd0);
    check("reset_count", 0, cnt[0], 32'd0);
    check("reset_count", 2, cnt[2], 32'd9);
    push(0, 32'd0, 1'b0);
    init_n = 1'b1;
    repeat (2) @(posedge clk);
    #1 check("latency_ko_early", 0, {31'd0, ko[0]}, 32'd0);
    @(posedge clk);
    #1 check("latency_ko_on_time", 0, {31'd0, ko[0]}, 32'd1);

    // Four-phase counting 0..4 then load priority, hold, down and wrap on 32 bits.
    for (int v = 1; v <= 4; v++) begin
      push(0, v, 1'b0);
      wave(0);
    end
    load = 1'b1; load_val = 32'd7;        push(0, 32'd7, 1'b0);  wave(0);
    load_val = 32'h55;                    push(0, 32'h55, 1'b0); wave(0);
    load = 1'b0; en = 1'b0;               push(0, 32'h55, 1'b0); wave(0);
                                          push(0, 32'h55, 1'b0); wave(0);
    en = 1'b1; dir = 1'b0;                push(0, 32'h54, 1'b0); wave(0);
    load = 1'b1; load_val = 32'd0;        push(0, 32'd0, 1'b0);  wave(0);
    load = 1'b0;                          push(0, 32'hFFFF_FFFF, 1'b1); wave(0);
    dir = 1'b1;                           push(0, 32'd0, 1'b1);  wave(0);
                                          push(0, 32'd1, 1'b0);  wave(0);

    // 4-bit STEP 3 wrap.
    en = 1'b0; load = 1'b0;               push(1, 32'd0, 1'b0);  wave(1);
    load = 1'b1; load_val = 32'd14;       push(1, 32'd14, 1'b0); wave(1);
    load = 1'b0; en = 1'b1; dir = 1'b1;   push(1, 32'd1, 1'b1);  wave(1);
                                          push(1, 32'd4, 1'b0);  wave(1);
    dir = 1'b0;                           push(1, 32'd1, 1'b0);  wave(1);
                                          push(1, 32'd14, 1'b1); wave(1);

    // 4-bit STEP 2 saturate, down then up.
    en = 1'b0; load = 1'b0;               push(2, 32'd9, 1'b0);  wave(2);
    load = 1'b1; load_val = 32'd1;        push(2, 32'd1, 1'b0);  wave(2);
    load = 1'b0; en = 1'b1; dir = 1'b0;   push(2, 32'd0, 1'b1);  wave(2);
                                          push(2, 32'd0, 1'b1);  wave(2);
    dir = 1'b1;                           push(2, 32'd2, 1'b0);  wave(2);
    load = 1'b1; load_val = 32'd14;       push(2, 32'd14, 1'b0); wave(2);
    load = 1'b0;                          push(2, 32'd15, 1'b1); wave(2);
                                          push(2, 32'd15, 1'b1); wave(2);
    en = 1'b0;

    // Reset while all three present DATA: NULL must appear before the next clock edge.
    @(posedge clk);
    #2 init_n = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      check("async_reset_ko", i, {31'd0, ko[i]}, 32'd0);
      check("async_reset_rails", i, st[i] | sf[i] | {31'd0, ct[i] | cf[i]}, 32'd0);
    end
    check("async_reset_count", 2, cnt[2], 32'd9);
    repeat (2) @(posedge clk);
    push(0, 32'd0, 1'b0);
    push(1, 32'd0, 1'b0);
    push(2, 32'd9, 1'b0);
    #1 init_n = 1'b1;
    for (int i = 0; i < 3; i++) wait_ko(i, 1'b1);
    repeat (3) @(posedge clk);

    check("queue_drained", 0, q0.size(), 32'd0);
    check("queue_drained", 1, q1.size(), 32'd0);
    check("queue_drained", 2, q2.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
